id_stage_pipe: RTL and testbench

- Next-generation instruction-decode stage for the 5-stage MIPS pipeline, sitting between IF/ID and EX.
- Decodes an extended logic/shift/load instruction subset and forwards operands from EX and MEM.
- Detects load-use hazards, raises a stall request, and owns the ID/EX pipeline register with stall, flush and bubble insertion.
- Keeps a saturating count of interlock stall cycles for performance monitoring.

---
 rtl/id_stage_pipe_if.sv | 56 +++++
 rtl/id_stage_pipe.sv | 231 +++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// Bundles the IF/ID-side inputs, forwarding paths and ID/EX outputs of the decode stage.
// The pipeline environment uses the master modport; the decode stage uses the slave modport.
interface id_stage_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
);
    logic [DATA_W-1:0]  pc_i;
    logic [31:0]        inst_i;
    logic               inst_valid_i;
    logic [DATA_W-1:0]  reg1_data_i;
    logic [DATA_W-1:0]  reg2_data_i;
    logic               reg1_read_o;
    logic               reg2_read_o;
    logic [RADDR_W-1:0] reg1_addr_o;
    logic [RADDR_W-1:0] reg2_addr_o;
    logic               ex_wreg_i;
    logic [RADDR_W-1:0] ex_wd_i;
    logic [DATA_W-1:0]  ex_wdata_i;
    logic               ex_is_load_i;
    logic               mem_wreg_i;
    logic [RADDR_W-1:0] mem_wd_i;
    logic [DATA_W-1:0]  mem_wdata_i;
    logic               stall_i;
    logic               flush_i;
    logic               stall_req_o;
    logic [7:0]         ex_aluop_o;
    logic [2:0]         ex_alusel_o;
    logic [DATA_W-1:0]  ex_reg1_o;
    logic [DATA_W-1:0]  ex_reg2_o;
    logic [RADDR_W-1:0] ex_wd_o;
    logic               ex_wreg_o;
    logic               ex_is_load_o;
    logic               ex_valid_o;
    logic [DATA_W-1:0]  ex_pc_o;
    logic               invalid_inst_o;
    logic [CNT_W-1:0]   stall_cnt_o;

    modport master (
        output pc_i, inst_i, inst_valid_i, reg1_data_i, reg2_data_i,
               ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
               mem_wreg_i, mem_wd_i, mem_wdata_i, stall_i, flush_i,
        input  reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stall_req_o,
               ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
               ex_is_load_o, ex_valid_o, ex_pc_o, invalid_inst_o, stall_cnt_o
    );

    modport slave (
        input  pc_i, inst_i, inst_valid_i, reg1_data_i, reg2_data_i,
               ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
               mem_wreg_i, mem_wd_i, mem_wdata_i, stall_i, flush_i,
        output reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stall_req_o,
               ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
               ex_is_load_o, ex_valid_o, ex_pc_o, invalid_inst_o, stall_cnt_o
    );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: decodes the logic/shift/load subset, forwards EX/MEM results,
// raises load-use interlocks and owns the ID/EX register plus a stall-cycle counter.
module id_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter bit FWD_EN  = 1'b1,
    parameter int CNT_W   = 16
) (
    input logic            clk,
    input logic            rst,
    id_stage_pipe_if.slave bus
);
    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;

    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_SRA = 6'h03;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;

    typedef struct packed {
        logic [7:0]         aluop;
        logic [2:0]         alusel;
        logic [DATA_W-1:0]  reg1;
        logic [DATA_W-1:0]  reg2;
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic               is_load;
        logic               valid;
        logic [DATA_W-1:0]  pc;
        logic               invalid;
    } idex_t;

    localparam idex_t BUBBLE = '0;

    logic [5:0]         op;
    logic [5:0]         funct;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         shamt;
    logic [15:0]        imm;
    logic               rd1;
    logic               rd2;
    logic [DATA_W-1:0]  imm_val;
    logic [RADDR_W-1:0] addr1;
    logic [RADDR_W-1:0] addr2;
    logic               hit_ex;
    logic               hit_mem;
    logic               stall_req;
    logic [CNT_W-1:0]   stall_cnt;
    idex_t              dec;
    idex_t              idex_q;

    assign op    = bus.inst_i[31:26];
    assign rs    = bus.inst_i[25:21];
    assign rt    = bus.inst_i[20:16];
    assign rd    = bus.inst_i[15:11];
    assign shamt = bus.inst_i[10:6];
    assign funct = bus.inst_i[5:0];
    assign imm   = bus.inst_i[15:0];
    assign addr1 = RADDR_W'(rs);
    assign addr2 = RADDR_W'(rt);

    // EX wins over MEM because it is the younger result; an EX load is never
    // forwarded since its data does not exist yet (the interlock covers it).
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic               rd_en,
        input logic [RADDR_W-1:0] addr,
        input logic [DATA_W-1:0]  rf_data,
        input logic [DATA_W-1:0]  imm_v,
        input logic               ex_wreg,
        input logic [RADDR_W-1:0] ex_wd,
        input logic [DATA_W-1:0]  ex_wdata,
        input logic               ex_load,
        input logic               mem_wreg,
        input logic [RADDR_W-1:0] mem_wd,
        input logic [DATA_W-1:0]  mem_wdata
    );
        logic [DATA_W-1:0] res;
        if (!rd_en)
            res = imm_v;
        else if (addr == '0)
            res = '0;
        else if (FWD_EN && ex_wreg && (ex_wd == addr) && !ex_load)
            res = ex_wdata;
        else if (FWD_EN && mem_wreg && (mem_wd == addr))
            res = mem_wdata;
        else
            res = rf_data;
        return res;
    endfunction

    always_comb begin
        dec         = BUBBLE;
        rd1         = 1'b0;
        rd2         = 1'b0;
        imm_val     = '0;
        dec.pc      = bus.pc_i;
        dec.valid   = 1'b1;
        dec.invalid = 1'b1;
        case (op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                rd1         = 1'b1;
                imm_val     = DATA_W'(imm);
                dec.wd      = addr2;
                dec.wreg    = 1'b1;
                dec.alusel  = EXE_RES_LOGIC;
                dec.invalid = 1'b0;
                dec.aluop   = (op == OP_ORI)  ? EXE_OR_OP :
                              (op == OP_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
            end
            OP_LUI: begin
                imm_val     = DATA_W'({imm, 16'h0000});
                dec.wd      = addr2;
                dec.wreg    = 1'b1;
                dec.aluop   = EXE_OR_OP;
                dec.alusel  = EXE_RES_LOGIC;
                dec.invalid = 1'b0;
            end
            OP_LW: begin
                rd1         = 1'b1;
                imm_val     = DATA_W'($signed(imm));
                dec.wd      = addr2;
                dec.wreg    = 1'b1;
                dec.is_load = 1'b1;
                dec.aluop   = EXE_LW_OP;
                dec.alusel  = EXE_RES_LOAD_STORE;
                dec.invalid = 1'b0;
            end
            OP_SPECIAL: begin
                case (funct)
                    F_AND, F_OR, F_XOR, F_NOR: begin
                        if (shamt == 5'd0) begin
                            rd1         = 1'b1;
                            rd2         = 1'b1;
                            dec.wd      = RADDR_W'(rd);
                            dec.wreg    = 1'b1;
                            dec.alusel  = EXE_RES_LOGIC;
                            dec.invalid = 1'b0;
                            dec.aluop   = (funct == F_AND) ? EXE_AND_OP :
                                          (funct == F_OR)  ? EXE_OR_OP  :
                                          (funct == F_XOR) ? EXE_XOR_OP : EXE_NOR_OP;
                        end
                    end
                    F_SLL, F_SRL, F_SRA: begin
                        if (rs == 5'd0) begin
                            rd2         = 1'b1;
                            imm_val     = DATA_W'(shamt);
                            dec.wd      = RADDR_W'(rd);
                            dec.wreg    = 1'b1;
                            dec.alusel  = EXE_RES_SHIFT;
                            dec.invalid = 1'b0;
                            dec.aluop   = (funct == F_SLL) ? EXE_SLL_OP :
                                          (funct == F_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        dec.reg1 = pick_operand(rd1, addr1, bus.reg1_data_i, imm_val,
                                bus.ex_wreg_i, bus.ex_wd_i, bus.ex_wdata_i, bus.ex_is_load_i,
                                bus.mem_wreg_i, bus.mem_wd_i, bus.mem_wdata_i);
        dec.reg2 = pick_operand(rd2, addr2, bus.reg2_data_i, imm_val,
                                bus.ex_wreg_i, bus.ex_wd_i, bus.ex_wdata_i, bus.ex_is_load_i,
                                bus.mem_wreg_i, bus.mem_wd_i, bus.mem_wdata_i);
    end

    // Without forwarding every in-flight producer of a source register must be waited out.
    assign hit_ex  = bus.ex_wreg_i && (bus.ex_wd_i != '0) &&
                     ((rd1 && (addr1 == bus.ex_wd_i)) || (rd2 && (addr2 == bus.ex_wd_i)));
    assign hit_mem = bus.mem_wreg_i && (bus.mem_wd_i != '0) &&
                     ((rd1 && (addr1 == bus.mem_wd_i)) || (rd2 && (addr2 == bus.mem_wd_i)));
    assign stall_req = bus.inst_valid_i &&
                       (FWD_EN ? (bus.ex_is_load_i && hit_ex) : (hit_ex || hit_mem));

    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_q    <= BUBBLE;
            stall_cnt <= '0;
        end else begin
            if (stall_req && !bus.stall_i && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (bus.flush_i)
                idex_q <= BUBBLE;
            else if (!bus.stall_i)
                idex_q <= (stall_req || !bus.inst_valid_i) ? BUBBLE : dec;
        end
    end

    assign bus.reg1_read_o    = rd1;
    assign bus.reg2_read_o    = rd2;
    assign bus.reg1_addr_o    = addr1;
    assign bus.reg2_addr_o    = addr2;
    assign bus.stall_req_o    = stall_req;
    assign bus.ex_aluop_o     = idex_q.aluop;
    assign bus.ex_alusel_o    = idex_q.alusel;
    assign bus.ex_reg1_o      = idex_q.reg1;
    assign bus.ex_reg2_o      = idex_q.reg2;
    assign bus.ex_wd_o        = idex_q.wd;
    assign bus.ex_wreg_o      = idex_q.wreg;
    assign bus.ex_is_load_o   = idex_q.is_load;
    assign bus.ex_valid_o     = idex_q.valid;
    assign bus.ex_pc_o        = idex_q.pc;
    assign bus.invalid_inst_o = idex_q.invalid;
    assign bus.stall_cnt_o    = stall_cnt;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: hand-encoded MIPS words with hand-computed ID/EX contents.
// A 3-bit stall counter keeps the saturation case short.
module tb_id_stage_pipe;
    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 3;

    logic clk;
    logic rst;
    int   test_count;
    int   fail_count;

    id_stage_pipe_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) bus ();

    id_stage_pipe #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .FWD_EN(1'b1), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] inst, input logic valid, input logic [31:0] pc);
        bus.inst_i       = inst;
        bus.inst_valid_i = valid;
        bus.pc_i         = pc;
    endtask

    task automatic setForward(input logic ex_wreg, input logic [4:0] ex_wd, input logic [31:0] ex_wdata,
                              input logic ex_load, input logic mem_wreg, input logic [4:0] mem_wd,
                              input logic [31:0] mem_wdata);
        bus.ex_wreg_i    = ex_wreg;
        bus.ex_wd_i      = ex_wd;
        bus.ex_wdata_i   = ex_wdata;
        bus.ex_is_load_i = ex_load;
        bus.mem_wreg_i   = mem_wreg;
        bus.mem_wd_i     = mem_wd;
        bus.mem_wdata_i  = mem_wdata;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_count = 0;
        fail_count = 0;
        rst = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.reg1_data_i = '0;
        bus.reg2_data_i = '0;
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        applyStimulus(32'h3401_1100, 1'b1, 32'h0000_0100);

        // reset held for two edges with ORI $1,$0,0x1100 presented
        step();
        step();
        checkOutput("rst_valid", 32'(bus.ex_valid_o), 32'h0);
        checkOutput("rst_wreg", 32'(bus.ex_wreg_o), 32'h0);
        checkOutput("rst_aluop", 32'(bus.ex_aluop_o), 32'h0);
        checkOutput("rst_reg2", bus.ex_reg2_o, 32'h0);
        checkOutput("rst_pc", bus.ex_pc_o, 32'h0);
        checkOutput("rst_cnt", 32'(bus.stall_cnt_o), 32'h0);

        rst = 1'b1;
        #1;
        checkOutput("ori_rd1", 32'(bus.reg1_read_o), 32'h1);
        checkOutput("ori_rd2", 32'(bus.reg2_read_o), 32'h0);
        checkOutput("ori_addr2", 32'(bus.reg2_addr_o), 32'h1);
        step();
        checkOutput("ori_reg1", bus.ex_reg1_o, 32'h0);
        checkOutput("ori_reg2", bus.ex_reg2_o, 32'h0000_1100);
        checkOutput("ori_wd", 32'(bus.ex_wd_o), 32'h1);
        checkOutput("ori_wreg", 32'(bus.ex_wreg_o), 32'h1);
        checkOutput("ori_aluop", 32'(bus.ex_aluop_o), 32'h25);
        checkOutput("ori_alusel", 32'(bus.ex_alusel_o), 32'h1);
        checkOutput("ori_valid", 32'(bus.ex_valid_o), 32'h1);
        checkOutput("ori_pc", bus.ex_pc_o, 32'h0000_0100);

        // OR $3,$1,$2 with $1 from EX and $2 from MEM
        setForward(1'b1, 5'd1, 32'hAAAA_0000, 1'b0, 1'b1, 5'd2, 32'h0000_5555);
        applyStimulus(32'h0022_1825, 1'b1, 32'h0000_0104);
        step();
        checkOutput("fwd_reg1", bus.ex_reg1_o, 32'hAAAA_0000);
        checkOutput("fwd_reg2", bus.ex_reg2_o, 32'h0000_5555);
        checkOutput("fwd_wd", 32'(bus.ex_wd_o), 32'h3);

        // both EX and MEM target $1: EX must win; $2 falls back to the register file
        bus.reg2_data_i = 32'h0000_0077;
        setForward(1'b1, 5'd1, 32'hAAAA_0000, 1'b0, 1'b1, 5'd1, 32'h0000_5555);
        step();
        checkOutput("prio_reg1", bus.ex_reg1_o, 32'hAAAA_0000);
        checkOutput("prio_reg2", bus.ex_reg2_o, 32'h0000_0077);

        // load-use: LW in EX writes $4, ID is ORI $5,$4,1
        bus.reg2_data_i = '0;
        setForward(1'b1, 5'd4, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0, 32'h0);
        applyStimulus(32'h3485_0001, 1'b1, 32'h0000_0108);
        #1;
        checkOutput("lu_req", 32'(bus.stall_req_o), 32'h1);
        step();
        checkOutput("lu_valid", 32'(bus.ex_valid_o), 32'h0);
        checkOutput("lu_wreg", 32'(bus.ex_wreg_o), 32'h0);
        checkOutput("lu_cnt", 32'(bus.stall_cnt_o), 32'h1);

        // load into $0 never interlocks
        setForward(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0, 32'h0);
        applyStimulus(32'h3405_0001, 1'b1, 32'h0000_010C);
        #1;
        checkOutput("zero_req", 32'(bus.stall_req_o), 32'h0);

        // SRA $8,$9,3
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        bus.reg2_data_i = 32'h8000_0000;
        applyStimulus(32'h0009_40C3, 1'b1, 32'h0000_0200);
        step();
        checkOutput("sra_aluop", 32'(bus.ex_aluop_o), 32'h03);
        checkOutput("sra_alusel", 32'(bus.ex_alusel_o), 32'h2);
        checkOutput("sra_reg1", bus.ex_reg1_o, 32'h3);
        checkOutput("sra_reg2", bus.ex_reg2_o, 32'h8000_0000);
        checkOutput("sra_wd", 32'(bus.ex_wd_o), 32'h8);

        // downstream stall holds ID/EX; interlock during stall must not count
        bus.stall_i = 1'b1;
        bus.reg2_data_i = '0;
        setForward(1'b1, 5'd4, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        applyStimulus(32'h3485_0001, 1'b1, 32'h0000_0204);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("hold%0d_aluop", i), 32'(bus.ex_aluop_o), 32'h03);
            checkOutput($sformatf("hold%0d_reg2", i), bus.ex_reg2_o, 32'h8000_0000);
            checkOutput($sformatf("hold%0d_cnt", i), 32'(bus.stall_cnt_o), 32'h1);
        end

        // flush beats stall
        bus.flush_i = 1'b1;
        step();
        checkOutput("flush_valid", 32'(bus.ex_valid_o), 32'h0);
        checkOutput("flush_aluop", 32'(bus.ex_aluop_o), 32'h0);
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;

        // LW $10,-4($11)
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        bus.reg1_data_i = 32'h0000_1000;
        applyStimulus(32'h8D6A_FFFC, 1'b1, 32'h0000_0300);
        step();
        checkOutput("lw_reg1", bus.ex_reg1_o, 32'h0000_1000);
        checkOutput("lw_reg2", bus.ex_reg2_o, 32'hFFFF_FFFC);
        checkOutput("lw_load", 32'(bus.ex_is_load_o), 32'h1);
        checkOutput("lw_wd", 32'(bus.ex_wd_o), 32'hA);
        checkOutput("lw_aluop", 32'(bus.ex_aluop_o), 32'hE3);
        checkOutput("lw_alusel", 32'(bus.ex_alusel_o), 32'h7);
        bus.reg1_data_i = '0;

        // unrecognised opcode
        applyStimulus(32'hFC00_0000, 1'b1, 32'h0000_0304);
        step();
        checkOutput("inv_flag", 32'(bus.invalid_inst_o), 32'h1);
        checkOutput("inv_wreg", 32'(bus.ex_wreg_o), 32'h0);
        checkOutput("inv_valid", 32'(bus.ex_valid_o), 32'h1);

        // bubble from IF/ID clears the invalid flag even for a bad encoding
        applyStimulus(32'hFC00_0000, 1'b0, 32'h0000_0308);
        step();
        checkOutput("bub_valid", 32'(bus.ex_valid_o), 32'h0);
        checkOutput("bub_inv", 32'(bus.invalid_inst_o), 32'h0);

        // LUI $7,0x1234
        applyStimulus(32'h3C07_1234, 1'b1, 32'h0000_030C);
        step();
        checkOutput("lui_reg1", bus.ex_reg1_o, 32'h1234_0000);
        checkOutput("lui_wd", 32'(bus.ex_wd_o), 32'h7);
        checkOutput("lui_wreg", 32'(bus.ex_wreg_o), 32'h1);

        // all-zero word is SLL $0,$0,0
        applyStimulus(32'h0000_0000, 1'b1, 32'h0000_0310);
        step();
        checkOutput("nop_valid", 32'(bus.ex_valid_o), 32'h1);
        checkOutput("nop_wreg", 32'(bus.ex_wreg_o), 32'h1);
        checkOutput("nop_wd", 32'(bus.ex_wd_o), 32'h0);
        checkOutput("nop_aluop", 32'(bus.ex_aluop_o), 32'h7C);
        checkOutput("nop_inv", 32'(bus.invalid_inst_o), 32'h0);

        // OR with non-zero shamt is not a legal encoding
        applyStimulus(32'h0022_1865, 1'b1, 32'h0000_0314);
        step();
        checkOutput("orsh_inv", 32'(bus.invalid_inst_o), 32'h1);
        checkOutput("orsh_wreg", 32'(bus.ex_wreg_o), 32'h0);

        // sustained interlock saturates the 3-bit counter at 7
        setForward(1'b1, 5'd4, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        applyStimulus(32'h3485_0001, 1'b1, 32'h0000_0318);
        for (int i = 0; i < 10; i++) step();
        checkOutput("sat_cnt", 32'(bus.stall_cnt_o), 32'h7);
        checkOutput("sat_valid", 32'(bus.ex_valid_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
